// File: rtl/ysyx_24080014_lsu_pkg.sv
// ysyx_24080014_lsu_pkg
//   Shared definitions for the load/store unit: funct3 access-size codes, FSM state
//   encoding and the request legality check used when a request is accepted.
//   No ports (package).
package ysyx_24080014_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    // 1 when the request must complete with an error and never reach the bus:
    // unsupported size code or an address not aligned to the access size.
    function automatic logic lsu_bad_req(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            LSU_B, LSU_BU: bad = 1'b0;
            LSU_H, LSU_HU: bad = addr_lo[0];
            LSU_W:         bad = |addr_lo;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_if.sv
// ysyx_24080014_lsu_if
//   Single-outstanding valid/ready memory bus between the LSU (master) and memory (slave).
//   bus_req_valid/ready : request handshake, fields held stable while valid && !ready
//   bus_req_wen         : 1 = write
//   bus_req_addr        : word-aligned address
//   bus_req_wdata/wmask : lane-shifted store data and byte strobes
//   bus_rsp_valid/rdata : response (read data or write ack)
interface ysyx_24080014_lsu_if #(
    parameter int unsigned XLEN = 32
);

    logic            bus_req_valid;
    logic            bus_req_ready;
    logic            bus_req_wen;
    logic [XLEN-1:0] bus_req_addr;
    logic [XLEN-1:0] bus_req_wdata;
    logic [3:0]      bus_req_wmask;
    logic            bus_rsp_valid;
    logic [XLEN-1:0] bus_rsp_rdata;

    modport master (
        output bus_req_valid,
        output bus_req_wen,
        output bus_req_addr,
        output bus_req_wdata,
        output bus_req_wmask,
        input  bus_req_ready,
        input  bus_rsp_valid,
        input  bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid,
        input  bus_req_wen,
        input  bus_req_addr,
        input  bus_req_wdata,
        input  bus_req_wmask,
        output bus_req_ready,
        output bus_rsp_valid,
        output bus_rsp_rdata
    );

endinterface

// File: rtl/ysyx_24080014_lsu_align.sv
// ysyx_24080014_lsu_align
//   Combinational byte-lane logic for the LSU (assumes XLEN = 32, four byte lanes).
//   i_st_funct3/i_st_addr_lo/i_st_data : store request -> o_st_wdata/o_st_wmask
//   i_ld_funct3/i_ld_addr_lo/i_ld_word : load response word -> o_ld_data (aligned, extended)
module ysyx_24080014_lsu_align
    import ysyx_24080014_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_st_funct3,
    input  logic [1:0]      i_st_addr_lo,
    input  logic [XLEN-1:0] i_st_data,
    output logic [XLEN-1:0] o_st_wdata,
    output logic [3:0]      o_st_wmask,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_addr_lo,
    input  logic [XLEN-1:0] i_ld_word,
    output logic [XLEN-1:0] o_ld_data
);

    logic [XLEN-1:0] w_ld_shifted;

    // Narrow stores replicate the value across all lanes; the strobe picks the lane.
    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wmask = 4'b1111;
        case (i_st_funct3[1:0])
            2'b00: begin
                o_st_wdata = {(XLEN/8){i_st_data[7:0]}};
                o_st_wmask = 4'b0001 << i_st_addr_lo;
            end
            2'b01: begin
                o_st_wdata = {(XLEN/16){i_st_data[15:0]}};
                o_st_wmask = 4'b0011 << i_st_addr_lo;
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_wmask = 4'b1111;
            end
        endcase
    end

    assign w_ld_shifted = i_ld_word >> {i_ld_addr_lo, 3'b000};

    always_comb begin
        o_ld_data = i_ld_word;
        case (i_ld_funct3)
            LSU_B:   o_ld_data = {{(XLEN-8){w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            LSU_H:   o_ld_data = {{(XLEN-16){w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            LSU_BU:  o_ld_data = {{(XLEN-8){1'b0}}, w_ld_shifted[7:0]};
            LSU_HU:  o_ld_data = {{(XLEN-16){1'b0}}, w_ld_shifted[15:0]};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu
//   Load/store unit: accepts one load or store, runs it over a single-outstanding
//   valid/ready bus and returns extended load data. Core stalls on lsu_busy.
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : request from EXE/MEM (sampled only while idle)
//   read_addr/mem_rd  : load / store address
//   store_data        : store value (low bytes valid)
//   lsu_busy          : request in flight
//   lsu_done/lsu_err  : one-cycle completion pulse / error (misaligned, bad size, timeout)
//   lsu_rdata         : extended load result, held until the next completion
//   bus               : memory bus, master side
module ysyx_24080014_lsu
    import ysyx_24080014_lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_is_load,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] read_addr,
    input  logic [XLEN-1:0] mem_rd,
    input  logic [XLEN-1:0] store_data,
    output logic            lsu_busy,
    output logic            lsu_done,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_err,
    ysyx_24080014_lsu_if.master bus
);

    // Keeps the counter legal when the watchdog is disabled.
    localparam int unsigned CntW = (TIMEOUT_W == 0) ? 1 : TIMEOUT_W;

    lsu_state_e      r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [XLEN-1:0] r_rdata;
    logic            r_bus_valid;
    logic            r_wen;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wmask;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [CntW-1:0] r_wdog;

    logic [XLEN-1:0] w_addr;
    logic            w_accept;
    logic            w_bad;
    logic            w_fire;
    logic [CntW-1:0] w_wdog_inc;
    logic            w_timeout;
    logic [XLEN-1:0] w_st_wdata;
    logic [3:0]      w_st_wmask;
    logic [XLEN-1:0] w_ld_data;
    logic [XLEN-1:0] w_rsp_data;

    assign w_addr     = req_is_load ? read_addr : mem_rd;
    assign w_accept   = req_valid & (req_is_load ^ req_is_store);
    assign w_bad      = lsu_bad_req(req_funct3, w_addr[1:0]);
    assign w_fire     = r_bus_valid & bus.bus_req_ready;
    assign w_wdog_inc = r_wdog + {{(CntW-1){1'b0}}, 1'b1};
    // Fires on the WAIT cycle whose count reaches all-ones (2^TIMEOUT_W - 1 WAIT cycles).
    assign w_timeout  = (TIMEOUT_W != 0) && (w_wdog_inc == {CntW{1'b1}});
    // Write acks carry no data back to the core.
    assign w_rsp_data = r_wen ? '0 : w_ld_data;

    ysyx_24080014_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .i_st_funct3 (req_funct3),
        .i_st_addr_lo(w_addr[1:0]),
        .i_st_data   (store_data),
        .o_st_wdata  (w_st_wdata),
        .o_st_wmask  (w_st_wmask),
        .i_ld_funct3 (r_funct3),
        .i_ld_addr_lo(r_addr_lo),
        .i_ld_word   (bus.bus_rsp_rdata),
        .o_ld_data   (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_bus_valid <= 1'b0;
            r_wen       <= 1'b0;
            r_bus_addr  <= '0;
            r_wdata     <= '0;
            r_wmask     <= 4'b0000;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_wdog      <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= w_addr[1:0];
                        r_busy    <= 1'b1;
                        if (w_bad) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= StReq;
                            r_bus_valid <= 1'b1;
                            r_wen       <= req_is_store;
                            r_bus_addr  <= {w_addr[XLEN-1:2], 2'b00};
                            r_wdata     <= req_is_store ? w_st_wdata : '0;
                            r_wmask     <= req_is_store ? w_st_wmask : 4'b0000;
                        end
                    end
                end
                StReq: begin
                    if (w_fire) begin
                        r_bus_valid <= 1'b0;
                        r_wdog      <= '0;
                        if (bus.bus_rsp_valid) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_rdata <= w_rsp_data;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus.bus_rsp_valid) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_rdata <= w_rsp_data;
                    end else if (w_timeout) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy  = r_busy;
    assign lsu_done  = r_done;
    assign lsu_err   = r_err;
    assign lsu_rdata = r_rdata;

    assign bus.bus_req_valid = r_bus_valid;
    assign bus.bus_req_wen   = r_wen;
    assign bus.bus_req_addr  = r_bus_addr;
    assign bus.bus_req_wdata = r_wdata;
    assign bus.bus_req_wmask = r_wmask;

endmodule
